mult_v2: RTL and testbench

MULT_V2 -- requirements
Module: mult_v2

---
 rtl/mult_v2_if.sv | 32 +++
 rtl/mult_v2.sv | 158 +++++++++++++++
 tb/tb_mult_v2.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_v2_if.sv
// Pixel/coefficient bus of the mult_v2 scaler: the master drives pixels, syncs and
// coefficient writes; the slave returns scaled pixels, delayed syncs and saturation stats.
interface mult_v2_if #(
  parameter int CH_COUNT      = 3,
  parameter int PIXEL_WIDTH   = 8,
  parameter int COE_WIDTH     = 16,
  parameter int SAT_CNT_WIDTH = 24
);
  logic [COE_WIDTH*CH_COUNT-1:0]   coe_i;
  logic                            coe_wr_i;
  logic                            coe_pend_o;
  logic [PIXEL_WIDTH*CH_COUNT-1:0] di_i;
  logic                            de_i;
  logic                            hs_i;
  logic                            vs_i;
  logic [PIXEL_WIDTH*CH_COUNT-1:0] do_o;
  logic                            de_o;
  logic                            hs_o;
  logic                            vs_o;
  logic [SAT_CNT_WIDTH-1:0]        sat_cnt_o;
  logic                            sat_cnt_vld_o;

  modport master (
    output coe_i, coe_wr_i, di_i, de_i, hs_i, vs_i,
    input  coe_pend_o, do_o, de_o, hs_o, vs_o, sat_cnt_o, sat_cnt_vld_o
  );

  modport slave (
    input  coe_i, coe_wr_i, di_i, de_i, hs_i, vs_i,
    output coe_pend_o, do_o, de_o, hs_o, vs_o, sat_cnt_o, sat_cnt_vld_o
  );
endinterface

// File: rtl/mult_v2.sv
// mult_v2: per-channel fixed-point pixel scaler (multiply, round, saturate) with
// frame-synchronous coefficient banks. Define MULT_V2_SAT_CNT_EN for the saturation counter.
module mult_v2 #(
  parameter int CH_COUNT           = 3,
  parameter int PIXEL_WIDTH        = 8,
  parameter int COE_WIDTH          = 16,
  parameter int COE_FRACTION_WIDTH = 10,
  parameter int SAT_CNT_WIDTH      = 24
) (
  input logic      clk,
  input logic      rst_n,
  mult_v2_if.slave bus
);
  localparam int PROD_W  = PIXEL_WIDTH + COE_WIDTH;
  localparam int PROD_W1 = PROD_W + 1;
  localparam int RND_W   = PROD_W1 - COE_FRACTION_WIDTH;
  localparam logic [COE_WIDTH-1:0] UNITY = COE_WIDTH'(1) << COE_FRACTION_WIDTH;
  localparam logic [PROD_W:0]      HALF  = PROD_W1'(1) << (COE_FRACTION_WIDTH - 1);

  logic                          vs_prev_q;
  logic                          frame_start;
  logic [COE_WIDTH*CH_COUNT-1:0] coe_act_q, coe_act_d;
  logic [COE_WIDTH*CH_COUNT-1:0] coe_shd_q, coe_shd_d;
  logic                          coe_pend_q, coe_pend_d;
  logic [2:0]                    de_pipe_q, de_pipe_d;
  logic [2:0]                    hs_pipe_q, hs_pipe_d;
  logic [2:0]                    vs_pipe_q, vs_pipe_d;
  logic [CH_COUNT-1:0]           sat_vec;

  // vs_prev resets high so a reset released mid-frame never looks like a frame start
  assign frame_start = bus.vs_i & ~vs_prev_q;

  always_comb begin
    coe_act_d  = coe_act_q;
    coe_shd_d  = coe_shd_q;
    coe_pend_d = coe_pend_q;
    if (bus.coe_wr_i && frame_start) begin
      coe_act_d  = bus.coe_i;
      coe_shd_d  = bus.coe_i;
      coe_pend_d = 1'b0;
    end else begin
      if (frame_start && coe_pend_q) begin
        coe_act_d  = coe_shd_q;
        coe_pend_d = 1'b0;
      end
      if (bus.coe_wr_i) begin
        coe_shd_d  = bus.coe_i;
        coe_pend_d = 1'b1;
      end
    end
  end

  always_comb begin
    de_pipe_d = {de_pipe_q[1:0], bus.de_i};
    hs_pipe_d = {hs_pipe_q[1:0], bus.hs_i};
    vs_pipe_d = {vs_pipe_q[1:0], bus.vs_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev_q  <= 1'b1;
      coe_act_q  <= {CH_COUNT{UNITY}};
      coe_shd_q  <= {CH_COUNT{UNITY}};
      coe_pend_q <= 1'b0;
      de_pipe_q  <= '0;
      hs_pipe_q  <= '0;
      vs_pipe_q  <= '0;
    end else begin
      vs_prev_q  <= bus.vs_i;
      coe_act_q  <= coe_act_d;
      coe_shd_q  <= coe_shd_d;
      coe_pend_q <= coe_pend_d;
      de_pipe_q  <= de_pipe_d;
      hs_pipe_q  <= hs_pipe_d;
      vs_pipe_q  <= vs_pipe_d;
    end
  end

  assign bus.coe_pend_o = coe_pend_q;
  assign bus.de_o       = de_pipe_q[2];
  assign bus.hs_o       = hs_pipe_q[2];
  assign bus.vs_o       = vs_pipe_q[2];

  for (genvar gi = 0; gi < CH_COUNT; gi++) begin : g_ch
    logic [PROD_W-1:0]      prod_q, prod_d;
    logic [RND_W-1:0]       rnd_q, rnd_d;
    logic [PIXEL_WIDTH-1:0] do_q, do_d;

    // rnd keeps only the integer part; anything above PIXEL_WIDTH means overflow
    assign sat_vec[gi] = |rnd_q[RND_W-1:PIXEL_WIDTH];

    always_comb begin
      prod_d = PROD_W'(bus.di_i[PIXEL_WIDTH*gi +: PIXEL_WIDTH])
             * PROD_W'(coe_act_q[COE_WIDTH*gi +: COE_WIDTH]);
      rnd_d  = RND_W'(({1'b0, prod_q} + HALF) >> COE_FRACTION_WIDTH);
      do_d   = sat_vec[gi] ? '1 : rnd_q[PIXEL_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prod_q <= '0;
        rnd_q  <= '0;
        do_q   <= '0;
      end else begin
        prod_q <= prod_d;
        rnd_q  <= rnd_d;
        do_q   <= do_d;
      end
    end

    assign bus.do_o[PIXEL_WIDTH*gi +: PIXEL_WIDTH] = do_q;
  end

`ifdef MULT_V2_SAT_CNT_EN
  logic [1:0]               fs_pipe_q, fs_pipe_d;
  logic [SAT_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [SAT_CNT_WIDTH-1:0] sat_cnt_q, sat_cnt_d;
  logic                     sat_vld_q, sat_vld_d;
  logic                     sat_inc;
  logic [SAT_CNT_WIDTH-1:0] cnt_inc;

  // The frame-start flag travels with the pixel, so it marks the vs_o rise exactly
  // and never fires for a vs_o rise that follows a reset.
  always_comb begin
    fs_pipe_d = {fs_pipe_q[0], frame_start};
    sat_inc   = de_pipe_q[1] & (|sat_vec);
    cnt_inc   = (sat_inc && (cnt_q != '1)) ? cnt_q + SAT_CNT_WIDTH'(1) : cnt_q;
    cnt_d     = cnt_inc;
    sat_cnt_d = sat_cnt_q;
    sat_vld_d = 1'b0;
    if (fs_pipe_q[1]) begin
      sat_cnt_d = cnt_inc;
      cnt_d     = '0;
      sat_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fs_pipe_q <= '0;
      cnt_q     <= '0;
      sat_cnt_q <= '0;
      sat_vld_q <= 1'b0;
    end else begin
      fs_pipe_q <= fs_pipe_d;
      cnt_q     <= cnt_d;
      sat_cnt_q <= sat_cnt_d;
      sat_vld_q <= sat_vld_d;
    end
  end

  assign bus.sat_cnt_o     = sat_cnt_q;
  assign bus.sat_cnt_vld_o = sat_vld_q;
`else
  assign bus.sat_cnt_o     = '0;
  assign bus.sat_cnt_vld_o = 1'b0;
`endif
endmodule

// File: tb/tb_mult_v2.sv
// Self-checking bench for mult_v2: directed and random pixels compared against an
// arithmetic reference model of scaling, coefficient banking and saturation counting.
module tb_mult_v2;
  localparam int CH  = 3;
  localparam int PW  = 8;
  localparam int CW  = 16;
  localparam int CFW = 10;
  localparam int SCW = 24;
`ifdef MULT_V2_SAT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mult_v2_if #(.CH_COUNT(CH), .PIXEL_WIDTH(PW), .COE_WIDTH(CW), .SAT_CNT_WIDTH(SCW)) bus ();

  mult_v2 #(
    .CH_COUNT(CH), .PIXEL_WIDTH(PW), .COE_WIDTH(CW),
    .COE_FRACTION_WIDTH(CFW), .SAT_CNT_WIDTH(SCW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct packed {
    logic [PW*CH-1:0] d;
    logic de, hs, vs, fs, sat;
  } exp_t;

  int      checks = 0;
  int      errors = 0;
  exp_t    pipe_q[$];
  int      act[CH];
  int      shd[CH];
  bit      pend;
  bit      prev_vs;
  longint  cnt;
  longint  exp_sat_cnt;
  bit      exp_vld;
  longint  cnt_max = (64'd1 << SCW) - 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_t z;
    z = '0;
    pipe_q.delete();
    pipe_q.push_back(z);
    pipe_q.push_back(z);
    for (int k = 0; k < CH; k++) begin
      act[k] = 1 << CFW;
      shd[k] = 1 << CFW;
    end
    pend = 0; prev_vs = 1; cnt = 0; exp_sat_cnt = 0; exp_vld = 0;
  endtask

  // One clock: apply the model to the inputs held across the edge, then check outputs.
  task automatic step();
    exp_t e, o;
    bit   fs;
    @(posedge clk);
    #1;
    fs = bus.vs_i && !prev_vs;
    prev_vs = bus.vs_i;
    e = '0;
    e.de = bus.de_i; e.hs = bus.hs_i; e.vs = bus.vs_i; e.fs = fs;
    for (int k = 0; k < CH; k++) begin
      int dv, r;
      dv = int'(bus.di_i[PW*k +: PW]);
      r  = (dv * act[k] + (1 << (CFW - 1))) / (1 << CFW);
      if (r > (1 << PW) - 1) begin
        r = (1 << PW) - 1;
        e.sat = 1'b1;
      end
      e.d[PW*k +: PW] = PW'(r);
    end
    pipe_q.push_back(e);
    if (bus.coe_wr_i && fs) begin
      for (int k = 0; k < CH; k++) begin
        act[k] = int'(bus.coe_i[CW*k +: CW]);
        shd[k] = act[k];
      end
      pend = 0;
    end else begin
      if (fs && pend) begin
        for (int k = 0; k < CH; k++) act[k] = shd[k];
        pend = 0;
      end
      if (bus.coe_wr_i) begin
        for (int k = 0; k < CH; k++) shd[k] = int'(bus.coe_i[CW*k +: CW]);
        pend = 1;
      end
    end
    o = pipe_q.pop_front();
    exp_vld = 0;
    if (CNT_EN) begin
      longint c;
      c = cnt + ((o.de && o.sat) ? 1 : 0);
      if (c > cnt_max) c = cnt_max;
      if (o.fs) begin
        exp_sat_cnt = c;
        cnt = 0;
        exp_vld = 1;
      end else begin
        cnt = c;
      end
    end
    check("do",      64'(bus.do_o),          64'(o.d));
    check("de",      64'(bus.de_o),          64'(o.de));
    check("hs",      64'(bus.hs_o),          64'(o.hs));
    check("vs",      64'(bus.vs_o),          64'(o.vs));
    check("pend",    64'(bus.coe_pend_o),    64'(pend));
    check("sat_cnt", 64'(bus.sat_cnt_o),     64'(exp_sat_cnt));
    check("sat_vld", 64'(bus.sat_cnt_vld_o), 64'(exp_vld));
  endtask

  task automatic set_pix(input logic [PW*CH-1:0] d, input logic de);
    bus.di_i = d;
    bus.de_i = de;
  endtask

  task automatic wr_coe(input int c0, input int c1, input int c2);
    bus.coe_i    = {CW'(c2), CW'(c1), CW'(c0)};
    bus.coe_wr_i = 1'b1;
    step();
    bus.coe_wr_i = 1'b0;
  endtask

  task automatic vs_pulse();
    bus.vs_i = 1'b1;
    step();
    step();
    bus.vs_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_do"},   64'(bus.do_o),          64'd0);
    check({tag, "_de"},   64'(bus.de_o),          64'd0);
    check({tag, "_hs"},   64'(bus.hs_o),          64'd0);
    check({tag, "_vs"},   64'(bus.vs_o),          64'd0);
    check({tag, "_pend"}, 64'(bus.coe_pend_o),    64'd0);
    check({tag, "_cnt"},  64'(bus.sat_cnt_o),     64'd0);
    check({tag, "_vld"},  64'(bus.sat_cnt_vld_o), 64'd0);
  endtask

  logic [PW-1:0] sat_ch2 [10];

  initial begin
    rst_n = 1'b0;
    bus.coe_i = '0; bus.coe_wr_i = 1'b0;
    bus.di_i = '0; bus.de_i = 1'b0; bus.hs_i = 1'b0; bus.vs_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    model_reset();

    // unity coefficients pass pixels through after exactly 3 cycles
    vs_pulse();
    set_pix(24'hFF007F, 1'b1);
    step();
    set_pix(24'h0, 1'b0);
    step();
    step();
    check("unity_do", 64'(bus.do_o), 64'hFF007F);
    check("unity_de", 64'(bus.de_o), 64'd1);

    // 0.5 / 1.0 / 2.0 written mid-frame, applied at next frame start
    wr_coe('h200, 'h400, 'h800);
    check("pend_set", 64'(bus.coe_pend_o), 64'd1);
    vs_pulse();
    check("pend_clr", 64'(bus.coe_pend_o), 64'd0);
    set_pix({8'h90, 8'h10, 8'h03}, 1'b1);
    step();
    set_pix({8'h7F, 8'h10, 8'h01}, 1'b1);
    step();
    set_pix(24'h0, 1'b0);
    step();
    check("round_sat_do", 64'(bus.do_o), 64'hFF1002);
    step();
    check("round_nosat_do", 64'(bus.do_o), 64'hFE1001);
    step();

    // frame with 10 active pixels, 4 saturating on channel 2
    sat_ch2 = '{8'h80, 8'h10, 8'hC0, 8'h20, 8'h7F, 8'hFF, 8'h00, 8'h90, 8'h01, 8'h40};
    vs_pulse();
    for (int i = 0; i < 10; i++) begin
      set_pix({sat_ch2[i], 8'($urandom), 8'($urandom)}, 1'b1);
      step();
    end
    set_pix(24'h0, 1'b0);
    repeat (3) step();
    bus.vs_i = 1'b1;
    step();
    step();
    bus.vs_i = 1'b0;
    step();
    check("frame_sat_cnt", 64'(bus.sat_cnt_o),     CNT_EN ? 64'd4 : 64'd0);
    check("frame_sat_vld", 64'(bus.sat_cnt_vld_o), CNT_EN ? 64'd1 : 64'd0);
    step();
    check("frame_vld_once", 64'(bus.sat_cnt_vld_o), 64'd0);

    // zero coefficients pending until the next frame start
    wr_coe(0, 0, 0);
    check("zero_pend", 64'(bus.coe_pend_o), 64'd1);
    set_pix(24'h405060, 1'b1);
    repeat (4) step();
    vs_pulse();
    set_pix(24'hFFFFFF, 1'b1);
    step();
    set_pix(24'h0, 1'b0);
    step();
    step();
    check("zero_do", 64'(bus.do_o), 64'd0);
    check("zero_pend_clr", 64'(bus.coe_pend_o), 64'd0);

    // write coincident with frame start goes straight to the active bank
    bus.vs_i = 1'b1;
    bus.coe_i = {16'h0400, 16'h0300, 16'h0500};
    bus.coe_wr_i = 1'b1;
    step();
    bus.coe_wr_i = 1'b0;
    check("direct_pend", 64'(bus.coe_pend_o), 64'd0);
    step();
    bus.vs_i = 1'b0;

    // randomized traffic with occasional coefficient writes
    for (int i = 0; i < 400; i++) begin
      bus.di_i = PW*CH'($urandom);
      bus.de_i = 1'($urandom);
      bus.hs_i = 1'($urandom);
      bus.vs_i = ((i % 50) < 2);
      if ($urandom_range(0, 19) == 0) begin
        bus.coe_i    = {CW'($urandom_range(0, 3000)), CW'($urandom_range(0, 3000)),
                        CW'($urandom_range(0, 3000))};
        bus.coe_wr_i = 1'b1;
      end
      step();
      bus.coe_wr_i = 1'b0;
    end

    // asynchronous reset in the middle of a frame with vs held high
    bus.vs_i = 1'b1;
    set_pix(24'hC0C0C0, 1'b1);
    wr_coe('h100, 'h100, 'h100);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    check_all_zero("rst_hold");
    rst_n = 1'b1;
    model_reset();
    repeat (5) step();
    bus.vs_i = 1'b0;
    repeat (4) step();
    vs_pulse();
    set_pix(24'hA0B0C0, 1'b1);
    repeat (6) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
